// File: rtl/escalonador_terminais_pkg.sv
// rtl/escalonador_terminais_pkg.sv - shared constants, state encoding and helpers for the terminal scheduler
package escalonador_pkg;

  localparam int N_TERM          = 2;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE   = 2'd1,
    RELEASE = 2'd2
  } estado_e;

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_SERVE   = SERVE;
  localparam logic [1:0] ST_RELEASE = RELEASE;

  // Index of the set bit in a one-hot vector of up to 8 stations (0 when empty).
  function automatic int idx_of(input logic [7:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (|(onehot & (8'd1 << i))) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/escalonador_terminais_if.sv
// rtl/escalonador_terminais_if.sv - request/grant bundle between the stations and the terminal scheduler
interface escalonador_terminais_if
  import escalonador_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]  req;
  logic [N_TERM-1:0] done;
  logic [N_REQ-1:0]  grant_t1;
  logic [N_REQ-1:0]  grant_t2;
  logic [N_TERM-1:0] term_ativo;
  logic              todos_ocupados;
  logic [N_TERM-1:0] timeout_evt;

  modport master (
    output req, done,
    input  grant_t1, grant_t2, term_ativo, todos_ocupados, timeout_evt
  );

  modport slave (
    input  req, done,
    output grant_t1, grant_t2, term_ativo, todos_ocupados, timeout_evt
  );

endinterface

// File: rtl/escalonador_terminais_seletor_rr.sv
// rtl/escalonador_terminais_seletor_rr.sv - find-first-set over a mask starting at a pointer, with wrap-around
module seletor_rr #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     mask,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic             valid
);

  // Walk the stations in rotation order from ptr and keep only the first requester.
  always_comb begin
    int               j;
    logic             found;
    logic [PTR_W-1:0] idx;
    pick  = '0;
    valid = |mask;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      idx = PTR_W'(j);
      if (!found && mask[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/escalonador_terminais.sv
// rtl/escalonador_terminais.sv - two-terminal round-robin scheduler; forced release under ESCALONADOR_TIMEOUT_EN
module escalonador_terminais
  import escalonador_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = 5
) (
  input logic                   clk,
  input logic                   rst,
  escalonador_terminais_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Marker block that only elaborates for a counter too narrow to reach the timeout.
  if (TIMEOUT_CYC < 2 || CNT_W < $clog2(TIMEOUT_CYC + 1)) begin : g_cfg_invalid
  end

  // The station register is kept through RELEASE so it stays blocked during the cool-down.
  logic [1:0]        st_q  [N_TERM];
  logic [1:0]        st_d  [N_TERM];
  logic [N_REQ-1:0]  sta_q [N_TERM];
  logic [N_REQ-1:0]  sta_d [N_TERM];
  logic [N_REQ-1:0]  pick_t[N_TERM];
  logic [N_TERM-1:0] valid_t;
  logic [N_TERM-1:0] to_hit;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              todos_q, todos_d;
  logic [N_REQ-1:0]  elig, mask_b, pick_a, pick_b, g_nxt0, g_nxt1;
  logic              valid_a, valid_b;

  function automatic logic [PTR_W-1:0] ptr_after(input logic [N_REQ-1:0] onehot);
    int idx;
    idx = idx_of(8'(onehot));
    return (idx >= N_REQ - 1) ? '0 : PTR_W'(idx + 1);
  endfunction

  // Eligible stations: requesting and not held by a terminal in SERVE or RELEASE.
  always_comb begin
    elig = bus.req;
    for (int t = 0; t < N_TERM; t++) begin
      if (st_q[t] != ST_IDLE) elig = elig & ~sta_q[t];
    end
    mask_b = (st_q[0] == ST_IDLE) ? (elig & ~pick_a) : elig;
  end

  seletor_rr #(.N(N_REQ), .PTR_W(PTR_W)) u_sel_a (
    .mask(elig), .ptr(ptr_q), .pick(pick_a), .valid(valid_a)
  );

  seletor_rr #(.N(N_REQ), .PTR_W(PTR_W)) u_sel_b (
    .mask(mask_b), .ptr(ptr_q), .pick(pick_b), .valid(valid_b)
  );

  // Terminal 2 always uses the cascaded pick; it equals the first pick when terminal 1 is busy.
  assign pick_t[0] = pick_a;
  assign pick_t[1] = pick_b;
  assign valid_t   = {valid_b, valid_a};

  // Per-terminal FSM next state, pointer advance and the busy flag from next-state grants.
  always_comb begin
    st_d  = st_q;
    sta_d = sta_q;
    ptr_d = ptr_q;
    for (int t = 0; t < N_TERM; t++) begin
      case (st_q[t])
        ST_IDLE: begin
          if (valid_t[t]) begin
            st_d[t]  = ST_SERVE;
            sta_d[t] = pick_t[t];
          end
        end
        ST_SERVE: begin
          if (bus.done[t] || !(|(bus.req & sta_q[t])) || to_hit[t]) st_d[t] = ST_RELEASE;
        end
        default: st_d[t] = ST_IDLE;
      endcase
    end
    if (st_q[1] == ST_IDLE && valid_b)      ptr_d = ptr_after(pick_b);
    else if (st_q[0] == ST_IDLE && valid_a) ptr_d = ptr_after(pick_a);
    g_nxt0  = (st_d[0] == ST_SERVE) ? sta_d[0] : '0;
    g_nxt1  = (st_d[1] == ST_SERVE) ? sta_d[1] : '0;
    todos_d = (st_d[0] == ST_SERVE) && (st_d[1] == ST_SERVE) && (|(bus.req & ~g_nxt0 & ~g_nxt1));
  end

  // Scheduler state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < N_TERM; t++) begin
        st_q[t]  <= ST_IDLE;
        sta_q[t] <= '0;
      end
      ptr_q   <= '0;
      todos_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      sta_q   <= sta_d;
      ptr_q   <= ptr_d;
      todos_q <= todos_d;
    end
  end

`ifdef ESCALONADOR_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt_q[N_TERM];
  logic [CNT_W-1:0]  cnt_d[N_TERM];
  logic [N_TERM-1:0] tevt_q, tevt_d;

  // Service counters; the event only fires when neither DONE nor abandon caused the release.
  always_comb begin
    for (int t = 0; t < N_TERM; t++) begin
      to_hit[t] = (st_q[t] == ST_SERVE) && (cnt_q[t] == CNT_W'(TIMEOUT_CYC - 1));
      tevt_d[t] = to_hit[t] && !bus.done[t] && (|(bus.req & sta_q[t]));
      cnt_d[t]  = cnt_q[t];
      if (st_q[t] == ST_IDLE) cnt_d[t] = '0;
      else if (st_q[t] == ST_SERVE && cnt_q[t] != CNT_W'(TIMEOUT_CYC - 1)) cnt_d[t] = cnt_q[t] + 1'b1;
    end
  end

  // Counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < N_TERM; t++) cnt_q[t] <= '0;
      tevt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tevt_q <= tevt_d;
    end
  end

  assign bus.timeout_evt = tevt_q;
`else
  assign to_hit          = '0;
  assign bus.timeout_evt = '0;
`endif

  assign bus.grant_t1       = (st_q[0] == ST_SERVE) ? sta_q[0] : '0;
  assign bus.grant_t2       = (st_q[1] == ST_SERVE) ? sta_q[1] : '0;
  assign bus.term_ativo     = {st_q[1] == ST_SERVE, st_q[0] == ST_SERVE};
  assign bus.todos_ocupados = todos_q;

endmodule

// File: tb/tb_escalonador_terminais.sv
// tb/tb_escalonador_terminais.sv - scoreboard bench for the two-terminal scheduler
module tb_escalonador_terminais;

  logic clk = 1'b0;
  logic rst = 1'b1;

  escalonador_terminais_if #(.N_REQ(4)) bus();

  escalonador_terminais #(.N_REQ(4), .TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [1:0]  done;
    logic [12:0] exp;
    string       name;
  } step_t;

  step_t sb[$];
  int checks = 0;
  int errors = 0;

  // Expected output tuple {grant_t1, grant_t2, term_ativo, todos_ocupados, timeout_evt}.
  function automatic logic [12:0] ob(logic [3:0] g1, logic [3:0] g2, logic [1:0] ativo, logic todos, logic [1:0] tevt);
    return {g1, g2, ativo, todos, tevt};
  endfunction

  function automatic void add(logic r, logic [3:0] q, logic [1:0] d, logic [12:0] e, string n);
    step_t s;
    s.rst = r; s.req = q; s.done = d; s.exp = e; s.name = n;
    sb.push_back(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t s;
    logic [12:0] got;
    add(1, 4'b0000, 2'b00, ob(4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00), "reset_idle");
    add(0, 4'b0010, 2'b00, ob(4'b0010, 4'b0000, 2'b01, 1'b0, 2'b00), "mid_grant");
    add(0, 4'b0010, 2'b00, ob(4'b0010, 4'b0000, 2'b01, 1'b0, 2'b00), "mid_hold");
    add(1, 4'b0010, 2'b00, ob(4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00), "reset_mid");
    add(1, 4'b0000, 2'b00, ob(4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00), "reset_hold");
    while (sb.size() > 0) begin
      s = sb.pop_front();
      rst = s.rst; bus.req = s.req; bus.done = s.done;
      tick();
      got = {bus.grant_t1, bus.grant_t2, bus.term_ativo, bus.todos_ocupados, bus.timeout_evt};
      checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s: got {g1,g2,ativo,todos,tevt}=%b required %b", s.name, got, s.exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    step_t s;
    logic [12:0] got;
    add(0, 4'b1111, 2'b00, ob(4'b0001, 4'b0010, 2'b11, 1'b1, 2'b00), "simul_grant");
    add(0, 4'b1111, 2'b00, ob(4'b0001, 4'b0010, 2'b11, 1'b1, 2'b00), "simul_hold");
    while (sb.size() > 0) begin
      s = sb.pop_front();
      rst = s.rst; bus.req = s.req; bus.done = s.done;
      tick();
      got = {bus.grant_t1, bus.grant_t2, bus.term_ativo, bus.todos_ocupados, bus.timeout_evt};
      checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s: got {g1,g2,ativo,todos,tevt}=%b required %b", s.name, got, s.exp);
      end
    end
  endtask

  task automatic test_fairness();
    step_t s;
    logic [12:0] got;
    logic [3:0] order[3];
    order[0] = 4'b0100; order[1] = 4'b1000; order[2] = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      add(0, 4'b1111, 2'b01, ob(4'b0000, 4'b0010, 2'b10, 1'b0, 2'b00), "fair_release");
      add(0, 4'b1111, 2'b00, ob(4'b0000, 4'b0010, 2'b10, 1'b0, 2'b00), "fair_cool");
      add(0, 4'b1111, 2'b00, ob(order[k], 4'b0010, 2'b11, 1'b1, 2'b00), "fair_next");
    end
    while (sb.size() > 0) begin
      s = sb.pop_front();
      rst = s.rst; bus.req = s.req; bus.done = s.done;
      tick();
      got = {bus.grant_t1, bus.grant_t2, bus.term_ativo, bus.todos_ocupados, bus.timeout_evt};
      checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s: got {g1,g2,ativo,todos,tevt}=%b required %b", s.name, got, s.exp);
      end
    end
  endtask

  task automatic test_saturation();
    step_t s;
    logic [12:0] got;
    add(1, 4'b0000, 2'b00, ob(4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00), "sat_reset");
    add(0, 4'b0111, 2'b00, ob(4'b0001, 4'b0010, 2'b11, 1'b1, 2'b00), "sat_full");
    add(0, 4'b0111, 2'b00, ob(4'b0001, 4'b0010, 2'b11, 1'b1, 2'b00), "sat_hold");
    add(0, 4'b0111, 2'b10, ob(4'b0001, 4'b0000, 2'b01, 1'b0, 2'b00), "sat_done");
    add(0, 4'b0101, 2'b00, ob(4'b0001, 4'b0000, 2'b01, 1'b0, 2'b00), "sat_cool");
    add(0, 4'b0101, 2'b00, ob(4'b0001, 4'b0100, 2'b11, 1'b0, 2'b00), "sat_regrant");
    while (sb.size() > 0) begin
      s = sb.pop_front();
      rst = s.rst; bus.req = s.req; bus.done = s.done;
      tick();
      got = {bus.grant_t1, bus.grant_t2, bus.term_ativo, bus.todos_ocupados, bus.timeout_evt};
      checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s: got {g1,g2,ativo,todos,tevt}=%b required %b", s.name, got, s.exp);
      end
    end
  endtask

  task automatic test_abandon();
    step_t s;
    logic [12:0] got;
    add(1, 4'b0000, 2'b00, ob(4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00), "ab_reset");
    add(0, 4'b1000, 2'b00, ob(4'b1000, 4'b0000, 2'b01, 1'b0, 2'b00), "ab_grant");
    add(0, 4'b0000, 2'b00, ob(4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00), "ab_drop");
    add(0, 4'b0000, 2'b00, ob(4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00), "ab_cool");
    add(0, 4'b0000, 2'b11, ob(4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00), "ab_done_idle");
    add(0, 4'b0001, 2'b00, ob(4'b0001, 4'b0000, 2'b01, 1'b0, 2'b00), "ab_regrant");
    add(0, 4'b0001, 2'b10, ob(4'b0001, 4'b0000, 2'b01, 1'b0, 2'b00), "ab_done_t2_idle");
    add(0, 4'b0000, 2'b01, ob(4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00), "ab_done_and_drop");
    add(0, 4'b0000, 2'b00, ob(4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00), "ab_end");
    while (sb.size() > 0) begin
      s = sb.pop_front();
      rst = s.rst; bus.req = s.req; bus.done = s.done;
      tick();
      got = {bus.grant_t1, bus.grant_t2, bus.term_ativo, bus.todos_ocupados, bus.timeout_evt};
      checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s: got {g1,g2,ativo,todos,tevt}=%b required %b", s.name, got, s.exp);
      end
    end
  endtask

  task automatic test_timeout();
    step_t s;
    logic [12:0] got;
    add(1, 4'b0000, 2'b00, ob(4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00), "to_reset");
    add(0, 4'b0001, 2'b00, ob(4'b0001, 4'b0000, 2'b01, 1'b0, 2'b00), "to_grant");
`ifdef ESCALONADOR_TIMEOUT_EN
    for (int k = 0; k < 15; k++)
      add(0, 4'b0001, 2'b00, ob(4'b0001, 4'b0000, 2'b01, 1'b0, 2'b00), "to_hold");
    add(0, 4'b0001, 2'b00, ob(4'b0000, 4'b0000, 2'b00, 1'b0, 2'b01), "to_fire");
    add(0, 4'b0001, 2'b00, ob(4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00), "to_pulse_end");
    add(0, 4'b0001, 2'b00, ob(4'b0001, 4'b0000, 2'b01, 1'b0, 2'b00), "to_regrant");
`else
    for (int k = 0; k < 100; k++)
      add(0, 4'b0001, 2'b00, ob(4'b0001, 4'b0000, 2'b01, 1'b0, 2'b00), "to_persist");
`endif
    add(1, 4'b0000, 2'b00, ob(4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00), "to_final_reset");
    while (sb.size() > 0) begin
      s = sb.pop_front();
      rst = s.rst; bus.req = s.req; bus.done = s.done;
      tick();
      got = {bus.grant_t1, bus.grant_t2, bus.term_ativo, bus.todos_ocupados, bus.timeout_evt};
      checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s: got {g1,g2,ativo,todos,tevt}=%b required %b", s.name, got, s.exp);
      end
    end
  endtask

  initial begin
    bus.req  = '0;
    bus.done = '0;
    test_reset();
    test_simultaneous();
    test_fairness();
    test_saturation();
    test_abandon();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1);
  end

endmodule
